// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 pins, deglitches the clock line and emits a
// one-cycle pulse on each filtered falling edge, with the synchronized data bit.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   clk_f;
  logic [CW-1:0]          cnt;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign data  = data_sync[SYNC_STAGES-1];

  // The filtered clock follows the synced clock only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_f     <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      fall      <= 1'b0;
      if (clk_s != clk_f) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          clk_f <= clk_s;
          cnt   <= '0;
          fall  <= ~clk_s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard frame receiver with E0/F0 prefix resolution into held scan-code events.
// Optional mid-frame timeout abort is enabled by defining PS2_TIMEOUT_EN.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scanCode,
  output logic       makeBreak,
  output logic       extended,
  output logic       valid,
  output logic       frame_err
);

  // valid/frame_err are single-cycle pulses with no back-pressure: a consumer
  // must sample scanCode/makeBreak/extended on the cycle valid is high or later.

  logic       fall;
  logic       data;
  ps2_state_t fsm_state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par;
  logic       pend_ext;
  logic       pend_brk;
  logic       stop_hit;
  logic       byte_rdy;
  logic       bad_frame;
  logic       timeout;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (data_pin_unused_guard(ps2_data)),
    .fall     (fall),
    .data     (data)
  );

  function automatic logic data_pin_unused_guard(input logic d);
    return d;
  endfunction

  // Stop-bit decisions are combinational so the event registers one clk later.
  assign stop_hit  = fall && (fsm_state == STOP);
  assign byte_rdy  = stop_hit && data && ps2_parity_ok(shreg, par);
  assign bad_frame = stop_hit && !byte_rdy;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || fall || (fsm_state == IDLE)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (fsm_state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
    end else if (timeout) begin
      fsm_state <= IDLE;
    end else if (fall) begin
      case (fsm_state)
        IDLE: begin
          if (!data) begin
            fsm_state <= DATA;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          shreg   <= {data, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) fsm_state <= PARITY;
        end
        PARITY: begin
          par       <= data;
          fsm_state <= STOP;
        end
        STOP: fsm_state <= IDLE;
        default: fsm_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scanCode  <= 8'h00;
      makeBreak <= 1'b0;
      extended  <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      pend_ext  <= 1'b0;
      pend_brk  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (byte_rdy) begin
        if (shreg == PS2_EXT_PREFIX) begin
          pend_ext <= 1'b1;
        end else if (shreg == PS2_BRK_PREFIX) begin
          pend_brk <= 1'b1;
        end else begin
          scanCode  <= shreg;
          makeBreak <= ~pend_brk;
          extended  <= pend_ext;
          valid     <= 1'b1;
          pend_ext  <= 1'b0;
          pend_brk  <= 1'b0;
        end
      end else if (bad_frame || timeout) begin
        frame_err <= 1'b1;
        pend_ext  <= 1'b0;
        pend_brk  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: bit-banged PS/2 frames, scoreboarded events.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scanCode;
  logic       makeBreak;
  logic       extended;
  logic       valid;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;

  // {err, code, makeBreak, extended}
  logic [10:0] exp_q[$];
  logic [9:0]  prev_out;

  ps2_scan_decoder #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scanCode  (scanCode),
    .makeBreak (makeBreak),
    .extended  (extended),
    .valid     (valid),
    .frame_err (frame_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of an 11-bit frame; glitch_at inserts a short clock
  // low pulse during the high phase before that bit index.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) begin
        wait_clks(HALF / 2);
        ps2_clk = 1'b0;
        wait_clks(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        wait_clks(HALF / 2);
      end
      ps2_bit(f[i]);
    end
    ps2_data = 1'b1;
    wait_clks(60);
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic mb, input logic ext);
    exp_q.push_back({1'b0, code, mb, ext});
  endtask

  task automatic expect_err();
    exp_q.push_back(11'h400);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] code,
                               input logic mb, input logic ext);
    check({tag, "_code"}, 32'(scanCode), 32'(code));
    check({tag, "_mb"}, 32'(makeBreak), 32'(mb));
    check({tag, "_ext"}, 32'(extended), 32'(ext));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [10:0] obs;
    logic [10:0] e;
    if (!reset) begin
      if (valid && frame_err) check("valid_and_err", 32'(1), 32'(0));
      if (!valid) check("outputs_held", 32'({scanCode, makeBreak, extended}), 32'(prev_out));
      if (valid || frame_err) begin
        obs = frame_err ? 11'h400 : {1'b0, scanCode, makeBreak, extended};
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(obs), 32'h7ff);
        end else begin
          e = exp_q.pop_front();
          check("event", 32'(obs), 32'(e));
        end
      end
    end
    prev_out = {scanCode, makeBreak, extended};
  end

  // ---------------- directed sequence ----------------
  initial begin
    wait_clks(5);
    check_outputs("reset", 8'h00, 1'b0, 1'b0);
    check("reset_valid", 32'(valid), 32'(0));
    check("reset_err", 32'(frame_err), 32'(0));
    reset = 1'b0;
    wait_clks(20);

    // 1: plain make
    expect_ev(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 11, -1);
    check_outputs("t1", 8'h29, 1'b1, 1'b0);

    // 2: break and extended break
    send_frame(8'hF0, 1'b0, 11, -1);
    expect_ev(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 11, -1);
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    expect_ev(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 11, -1);
    check_outputs("t2", 8'h75, 1'b0, 1'b1);

    // 3: parity error holds outputs and clears a pending break
    expect_ev(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 11, -1);
    expect_err();
    send_frame(8'h29, 1'b1, 11, -1);
    check_outputs("t3_hold", 8'h29, 1'b1, 1'b0);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    expect_err();
    send_frame(8'h33, 1'b1, 11, -1);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11, -1);
    check("t3_queue", 32'(exp_q.size()), 32'(0));

    // 4: short clock glitch mid-DATA is ignored
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 4);
    check("t4_queue", 32'(exp_q.size()), 32'(0));

    // 5: truncated frame
`ifdef PS2_TIMEOUT_EN
    expect_err();
    send_frame(8'h55, 1'b0, 5, -1);
    wait_clks(TIMEOUT_CYCLES + 200);
    check("t5_queue_err", 32'(exp_q.size()), 32'(0));
    expect_ev(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 11, -1);
`else
    send_frame(8'h55, 1'b0, 5, -1);
    wait_clks(3000);
`endif
    check("t5_queue", 32'(exp_q.size()), 32'(0));

    // 6: reset mid-frame discards the partial byte
    send_frame(8'h55, 1'b0, 5, -1);
    reset = 1'b1;
    wait_clks(3);
    check_outputs("t6_reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    wait_clks(10);
    expect_ev(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 11, -1);
    check_outputs("t6", 8'h29, 1'b1, 1'b0);

    wait_clks(200);
    check("final_queue", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
